// File: rtl/accelerator_pkg.sv
// accelerator_pkg: register offsets, CTRL/STATUS bit indices and multiplier sizing.
package accelerator_pkg;
    localparam int OFF_OPA = 'h000;
    localparam int OFF_OPB = 'h004;
    localparam int OFF_CTRL = 'h008;
    localparam int OFF_STATUS = 'h00C;
    localparam int OFF_RESULT = 'h010;
    localparam int CTRL_START = 0;
    localparam int CTRL_IE = 1;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int OP_WIDTH = 32;
    localparam int ITERATIONS = 32;
    localparam int COUNT_WIDTH = $clog2(ITERATIONS);
endpackage

// File: rtl/accel_mul_core.sv
// accel_mul_core: iterative unsigned shift-add multiplier, one partial product per cycle.
module accel_mul_core
    import accelerator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OP_WIDTH-1:0]   opa,
    input  logic [OP_WIDTH-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [2*OP_WIDTH-1:0] product
);
    logic [2*OP_WIDTH-1:0] mcand;
    logic [OP_WIDTH-1:0] mplier;
    logic [COUNT_WIDTH-1:0] count;
    logic lastIter;

    assign lastIter = count == COUNT_WIDTH'(ITERATIONS - 1);
    // done pulses during the final iteration so the top can latch DONE on the same edge
    assign done = busy & lastIter;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            product <= '0;
            mcand <= '0;
            mplier <= '0;
            count <= '0;
        end else if (start) begin
            busy <= 1'b1;
            product <= '0;
            mcand <= {{OP_WIDTH{1'b0}}, opa};
            mplier <= opb;
            count <= '0;
        end else if (busy) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            count <= count + 1'b1;
            busy <= ~lastIter;
        end
    end
endmodule

// File: rtl/accelerator.sv
// accelerator: memory-mapped 32x32 multiplier with register file and one-cycle handshake.
// Define ACCEL_IRQ_EN to build the IE bit and the registered interrupt output.
module accelerator
    import accelerator_pkg::*;
#(
    parameter int dataWidth = 8,
    parameter int addrWidth = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 readmem,
    input  logic                 writemem,
    input  logic [addrWidth-1:0] address,
    input  logic [dataWidth-1:0] dataIn,
    output logic [dataWidth-1:0] dataOut,
    output logic                 memDataReady,
    output logic                 interrupt
);
    logic [OP_WIDTH-1:0] opa, opb;
    logic [2*OP_WIDTH-1:0] product;
    logic busy, mulDone, done, ie;
    logic wrFirst, startReq;
    logic selOpa, selOpb, selCtrl, selStatus, selResult;
    logic [dataWidth-1:0] ctrlByte, statusByte, rdByte;

    assign selOpa = address[addrWidth-1:2] == (addrWidth-2)'(OFF_OPA >> 2);
    assign selOpb = address[addrWidth-1:2] == (addrWidth-2)'(OFF_OPB >> 2);
    assign selCtrl = address == addrWidth'(OFF_CTRL);
    assign selStatus = address == addrWidth'(OFF_STATUS);
    assign selResult = address[addrWidth-1:3] == (addrWidth-3)'(OFF_RESULT >> 3);

    // a held request only acts once: side effects are gated off once the handshake is up
    assign wrFirst = cs & writemem & ~memDataReady;
    assign startReq = wrFirst & selCtrl & dataIn[CTRL_START] & ~busy;

    accel_mul_core mulCore (
        .clk(clk),
        .rst(rst),
        .start(startReq),
        .opa(opa),
        .opb(opb),
        .busy(busy),
        .done(mulDone),
        .product(product)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            opa <= '0;
            opb <= '0;
            done <= 1'b0;
            memDataReady <= 1'b0;
        end else begin
            memDataReady <= cs & (readmem | writemem);
            if (wrFirst && selOpa && !busy) opa[{address[1:0], 3'b000} +: dataWidth] <= dataIn;
            if (wrFirst && selOpb && !busy) opb[{address[1:0], 3'b000} +: dataWidth] <= dataIn;
            // completion outranks a same-cycle software clear
            done <= startReq ? 1'b0 :
                    mulDone ? 1'b1 :
                    (wrFirst && selStatus && dataIn[STATUS_DONE]) ? 1'b0 : done;
        end
    end

`ifdef ACCEL_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ie <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (wrFirst && selCtrl) ie <= dataIn[CTRL_IE];
            interrupt <= done & ie;
        end
    end
`else
    assign ie = 1'b0;
    assign interrupt = 1'b0;
`endif

    always_comb begin
        ctrlByte = '0;
        ctrlByte[CTRL_IE] = ie;
        statusByte = '0;
        statusByte[STATUS_BUSY] = busy;
        statusByte[STATUS_DONE] = done;
    end

    assign rdByte = selOpa ? opa[{address[1:0], 3'b000} +: dataWidth] :
                    selOpb ? opb[{address[1:0], 3'b000} +: dataWidth] :
                    selCtrl ? ctrlByte :
                    selStatus ? statusByte :
                    selResult ? product[{address[2:0], 3'b000} +: dataWidth] : '0;
    assign dataOut = (cs & readmem) ? rdByte : '0;
endmodule

// File: tb/tb_accelerator.sv
// tb_accelerator: directed self-checking bench for the accelerator register interface and multiplier.
module tb_accelerator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cs = 1'b0;
    logic readmem = 1'b0;
    logic writemem = 1'b0;
    logic [11:0] address = '0;
    logic [7:0] dataIn = '0;
    logic [7:0] dataOut;
    logic memDataReady;
    logic interrupt;
    int checks = 0;
    int errors = 0;
    logic [7:0] b;
    logic [31:0] w;
    logic [63:0] r;

`ifdef ACCEL_IRQ_EN
    localparam logic [7:0] EXP_IE = 8'h02;
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic [7:0] EXP_IE = 8'h00;
    localparam logic EXP_IRQ = 1'b0;
`endif

    accelerator #(.dataWidth(8), .addrWidth(12)) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .readmem(readmem),
        .writemem(writemem),
        .address(address),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .memDataReady(memDataReady),
        .interrupt(interrupt)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1;
        writemem = 1'b1;
        address = a;
        dataIn = d;
        @(negedge clk);
        cs = 1'b0;
        writemem = 1'b0;
    endtask

    task automatic wrWord(input logic [11:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) wr(a + 12'(i), d[8*i +: 8]);
    endtask

    // combinational read with no clock edge inside, so no handshake side effect
    task automatic peek(input logic [11:0] a, output logic [7:0] d);
        cs = 1'b1;
        readmem = 1'b1;
        address = a;
        #1;
        d = dataOut;
        cs = 1'b0;
        readmem = 1'b0;
        #1;
    endtask

    task automatic peekWord(input logic [11:0] a, output logic [31:0] d);
        logic [7:0] t;
        for (int i = 0; i < 4; i++) begin
            peek(a + 12'(i), t);
            d[8*i +: 8] = t;
        end
    endtask

    task automatic peekResult(output logic [63:0] d);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            peek(12'h010 + 12'(i), t);
            d[8*i +: 8] = t;
        end
    endtask

    task automatic startMul(input logic [31:0] a, input logic [31:0] bb, input logic [7:0] ctrl);
        wrWord(12'h000, a);
        wrWord(12'h004, bb);
        wr(12'h008, ctrl);
    endtask

    initial begin
        cyc(3);
        check("reset_ready", memDataReady, 0);
        check("reset_irq", interrupt, 0);
        rst = 1'b1;
        cyc(1);
        peekWord(12'h000, w);
        check("reset_opa", w, 0);
        peek(12'h00C, b);
        check("reset_status", b, 0);
        peekResult(r);
        check("reset_result", r, 0);

        // unmapped read handshake
        @(negedge clk);
        cs = 1'b1;
        readmem = 1'b1;
        address = 12'h020;
        #1;
        check("unmapped_data", dataOut, 0);
        check("ready_before_edge", memDataReady, 0);
        @(negedge clk);
        check("ready_latency", memDataReady, 1);
        @(negedge clk);
        check("ready_held", memDataReady, 1);
        cs = 1'b0;
        @(negedge clk);
        check("ready_drop", memDataReady, 0);
        check("cs_low_data", dataOut, 0);
        @(negedge clk);
        check("cs_low_ready", memDataReady, 0);
        readmem = 1'b0;

        // held write only takes effect in its first cycle
        @(negedge clk);
        cs = 1'b1;
        writemem = 1'b1;
        address = 12'h000;
        dataIn = 8'h11;
        @(negedge clk);
        dataIn = 8'h22;
        @(negedge clk);
        cs = 1'b0;
        writemem = 1'b0;
        peek(12'h000, b);
        check("held_write_once", b, 8'h11);

        // 7 * 6 with exact completion timing
        startMul(32'd7, 32'd6, 8'h01);
        peek(12'h00C, b);
        check("busy_after_start", b, 8'h01);
        peek(12'h008, b);
        check("start_reads_zero", b, 8'h00);
        cyc(31);
        peek(12'h00C, b);
        check("busy_at_31", b, 8'h01);
        cyc(1);
        peek(12'h00C, b);
        check("done_at_32", b, 8'h02);
        peekResult(r);
        check("result_7x6", r, 64'h2A);

        // max operands; start also clears a pending DONE
        startMul(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h01);
        peek(12'h00C, b);
        check("start_clears_done", b, 8'h01);
        cyc(32);
        peekResult(r);
        check("result_max", r, 64'hFFFFFFFE_00000001);
        peek(12'h010, b);
        check("result_byte0", b, 8'h01);
        peek(12'h014, b);
        check("result_byte4", b, 8'hFE);

        // interrupt path
        wr(12'h008, 8'h02);
        peek(12'h008, b);
        check("ie_readback", b, EXP_IE);
        startMul(32'd3, 32'd5, 8'h03);
        cyc(32);
        peek(12'h00C, b);
        check("irq_done", b, 8'h02);
        check("irq_not_yet", interrupt, 0);
        cyc(1);
        check("irq_asserted", interrupt, EXP_IRQ);
        peekResult(r);
        check("result_3x5", r, 64'd15);
        wr(12'h00C, 8'h02);
        peek(12'h00C, b);
        check("done_cleared", b, 8'h00);
        cyc(1);
        check("irq_cleared", interrupt, 0);

        // completion beats a same-cycle DONE clear
        startMul(32'd2, 32'd3, 8'h01);
        cyc(30);
        wr(12'h00C, 8'h02);
        peek(12'h00C, b);
        check("done_wins_clear", b, 8'h02);

        // operand and START writes ignored while busy
        startMul(32'h00001234, 32'h00000100, 8'h01);
        cyc(8);
        wr(12'h000, 8'h09);
        wr(12'h008, 8'h01);
        cyc(19);
        peek(12'h00C, b);
        check("busy_ignore_31", b, 8'h01);
        cyc(1);
        peek(12'h00C, b);
        check("busy_ignore_done", b, 8'h02);
        peekResult(r);
        check("busy_ignore_result", r, 64'h123400);
        peekWord(12'h000, w);
        check("busy_ignore_opa", w, 32'h1234);

        // reset mid-multiply aborts with nothing left behind
        wr(12'h008, 8'h02);
        startMul(32'd7, 32'd6, 8'h03);
        cyc(14);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        peek(12'h00C, b);
        check("abort_status", b, 8'h00);
        peek(12'h008, b);
        check("abort_ie", b, 8'h00);
        peekWord(12'h000, w);
        check("abort_opa", w, 0);
        peekResult(r);
        check("abort_result", r, 0);
        check("abort_ready", memDataReady, 0);
        cyc(40);
        peek(12'h00C, b);
        check("abort_no_done", b, 8'h00);
        check("abort_irq", interrupt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accelerator.md
ACCELERATOR -- requirements
Module: accelerator

Interface
REQ-001 The block SHALL have parameter dataWidth, default 8, meaning bus data width (only 8 supported).
REQ-002 The block SHALL have parameter addrWidth, default 12, meaning local byte-address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; rising-edge only.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-low.
REQ-005 The block SHALL have port cs, input, 1, meaning chip select from the address decoder.
REQ-006 The block SHALL have port readmem, input, 1, meaning read request.
REQ-007 The block SHALL have port writemem, input, 1, meaning write request.
REQ-008 The block SHALL have port address, input, addrWidth, meaning byte offset within the block.
REQ-009 The block SHALL have port dataIn, input, dataWidth, meaning write data.
REQ-010 The block SHALL have port dataOut, output, dataWidth, meaning read data.
REQ-011 The block SHALL have port memDataReady, output, 1, meaning access-complete handshake.
REQ-012 The block SHALL have port interrupt, output, 1, meaning level interrupt to the core (machine external).

Function
REQ-013 Register map (byte offsets, little-endian multi-byte): 0x000-0x003 OPA[31:0]; 0x004-0x007 OPB[31:0]; 0x008 CTRL (bit0 START, bit1 IE); 0x00C STATUS (bit0 BUSY, bit1 DONE); 0x010-0x017 RESULT[63:0] read-only.
REQ-014 Unmapped offsets SHALL read 0x00 and ignore writes; dataOut SHALL be 0x00 whenever cs=0.
REQ-015 Handshake: memDataReady SHALL be a register equal to cs&(readmem|writemem) from the previous cycle, so it has one-cycle latency and stays high while the request is held.
REQ-016 Write side-effects SHALL occur only in the first request cycle (cs&writemem&~memDataReady); read data SHALL be combinational from address while cs&readmem.
REQ-017 Writing 1 to START while BUSY=0 SHALL clear RESULT and DONE, set BUSY and start a 32-iteration unsigned shift-add multiply of OPA by OPB; START SHALL read 0.
REQ-018 START writes, and OPA/OPB writes, SHALL be ignored while BUSY=1.
REQ-019 Exactly 32 cycles after the START-write cycle, RESULT SHALL hold the full 64-bit OPA*OPB, BUSY SHALL be 0 and DONE SHALL be 1.
REQ-020 Writing 1 to STATUS bit1 SHALL clear DONE; if a completion and a clear occur in the same cycle, the completion SHALL win and DONE=1.
REQ-021 interrupt SHALL equal DONE & IE, registered (asserted the cycle after DONE rises while IE=1).
REQ-022 CTRL bit1 (IE) SHALL be read/write; all other CTRL/STATUS bits SHALL read 0.

Reset
REQ-023 With rst=0 at a clock edge, OPA, OPB, RESULT, IE, BUSY, DONE, memDataReady and interrupt SHALL become 0; a reset during a multiply SHALL abort it with no DONE.

Configuration
REQ-024 Macro ACCEL_IRQ_EN defined SHALL compile in IE and interrupt logic per REQ-021; without it, interrupt SHALL be tied 0 and IE SHALL read 0 and ignore writes.

Structure
REQ-025 Package accelerator_pkg SHALL hold the register offsets, CTRL/STATUS bit indices, operand width (32) and the iteration count (32).
REQ-026 The iterative datapath SHALL be the sub-module accel_mul_core (ports: start, opa, opb, busy, done pulse, product); register file, decode and handshake SHALL stay in the top.

Verification
REQ-027 OPA=7, OPB=6, START -> BUSY=1 next cycle; after 32 cycles RESULT=0x2A, DONE=1, BUSY=0.
REQ-028 OPA=OPB=0xFFFFFFFF, START -> RESULT bytes 0x010..0x017 read 01 00 00 00 FE FF FF FF.
REQ-029 IE=1, OPA=3, OPB=5, START -> interrupt=1 one cycle after DONE; write 0x02 to STATUS -> DONE=0 and interrupt=0.
REQ-030 START, then at cycle 10 write OPA=9 and START again -> ignored; final RESULT is the original product, completing at cycle 32.
REQ-031 rst=0 at cycle 15 of a multiply -> all registers 0, DONE never set, interrupt stays 0.
REQ-032 Read offset 0x020 with cs=1 -> memDataReady=1 next cycle, dataOut=0x00; with cs=0, memDataReady stays 0.
